// File: rtl/fact_pkg.sv
// -----------------------------------------------------------------------------
// fact_pkg
// Definitions shared by the factorial compute engine and its sequential
// multiplier: default widths, the multiplier iteration count and the FSM
// state encoding.
// -----------------------------------------------------------------------------
package fact_pkg;

  localparam int OPW_DEF   = 64;    // operand width
  localparam int RESW_DEF  = 128;   // result width (result is N! mod 2^RESW)
  localparam int MUL_ITERS = OPW_DEF; // shift-add iterations per multiply

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    MUL   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage : fact_pkg

// File: rtl/fact_mul_seq.sv
// -----------------------------------------------------------------------------
// fact_mul_seq
// Sequential shift-add multiplier. Consumes one bit of b per cycle, LSB
// first, for ITERS cycles. Only the low RESW bits of a*b are kept; the
// shifted copy of a is truncated to RESW bits every step.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   clear    in   synchronous abort; discards any multiply in flight
//   start    in   load a/b and begin; ignored while clear is high
//   a        in   RESW-bit multiplicand
//   b        in   OPW-bit multiplier
//   done     out  1-cycle pulse in the cycle after the last iteration
//   product  out  low RESW bits of a*b, valid while done is high
// -----------------------------------------------------------------------------
module fact_mul_seq
  import fact_pkg::*;
#(
  parameter int OPW   = OPW_DEF,
  parameter int RESW  = RESW_DEF,
  parameter int ITERS = MUL_ITERS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            start,
  input  logic [RESW-1:0] a,
  input  logic [OPW-1:0]  b,
  output logic            done,
  output logic [RESW-1:0] product
);

  localparam int CW = $clog2(ITERS + 1);

  logic [RESW-1:0] a_q;
  logic [RESW-1:0] acc_q;
  logic [OPW-1:0]  b_q;
  logic [CW-1:0]   bit_cnt_q;
  logic            done_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      a_q       <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        a_q       <= a;
        b_q       <= b;
        acc_q     <= '0;
        bit_cnt_q <= CW'(ITERS);
      end else if (bit_cnt_q != '0) begin
        if (b_q[0]) begin
          acc_q <= acc_q + a_q;
        end
        a_q       <= a_q << 1;
        b_q       <= b_q >> 1;
        bit_cnt_q <= bit_cnt_q - CW'(1);
        // Terminal count: the last iteration lands this edge, so the
        // accumulator is final in the following cycle.
        if (bit_cnt_q == CW'(1)) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule : fact_mul_seq

// File: rtl/factorial_core.sv
// -----------------------------------------------------------------------------
// factorial_core
// Iterative N! engine. Captures the operand on start, seeds the result with
// 1 and multiplies it by cnt, cnt-1, ... down to 2 using fact_mul_seq.
// The result wraps modulo 2^RESW without any overflow indication.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for op_start; result holds (0 after reset/clear)
// LOAD  | result <= 1
// CHECK | cnt<=1 -> DONE, else launch multiply result*cnt
// MUL   | multiplier running; on its done pulse write back, cnt--
// DONE  | op_done high, result holds; op_start restarts
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   op_start  in   start request, honoured only in IDLE or DONE
//   op_clear  in   synchronous abort/clear
//   intr_en   in   interrupt enable
//   operand   in   N, captured in the start cycle
//   busy      out  high in LOAD, CHECK and MUL
//   op_done   out  high in DONE
//   result    out  accumulator, valid while op_done is high
//   intr      out  op_done & intr_en
// -----------------------------------------------------------------------------
module factorial_core
  import fact_pkg::*;
#(
  parameter int OPW  = OPW_DEF,
  parameter int RESW = RESW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_start,
  input  logic            op_clear,
  input  logic            intr_en,
  input  logic [OPW-1:0]  operand,
  output logic            busy,
  output logic            op_done,
  output logic [RESW-1:0] result,
  output logic            intr
);

  state_t          state_q;
  logic [OPW-1:0]  cnt_q;
  logic [RESW-1:0] result_q;
  logic            busy_q;
  logic            done_q;

  logic            mul_start;
  logic            mul_done;
  logic [RESW-1:0] mul_product;

  // A clear in the same cycle also clears the multiplier, which overrides
  // its start, so no gating is needed here.
  assign mul_start = (state_q == CHECK) && (cnt_q > OPW'(1));

  fact_mul_seq #(
    .OPW   (OPW),
    .RESW  (RESW),
    .ITERS (OPW)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .clear   (op_clear),
    .start   (mul_start),
    .a       (result_q),
    .b       (cnt_q),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (op_clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (op_start) begin
            cnt_q   <= operand;
            state_q <= LOAD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        LOAD: begin
          result_q <= RESW'(1);
          state_q  <= CHECK;
        end
        CHECK: begin
          // Exiting at cnt<=1 is what keeps cnt from ever underflowing.
          if (cnt_q <= OPW'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= MUL;
          end
        end
        MUL: begin
          if (mul_done) begin
            result_q <= mul_product;
            cnt_q    <= cnt_q - OPW'(1);
            state_q  <= CHECK;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign op_done = done_q;
  assign result  = result_q;
  assign intr    = done_q & intr_en;

endmodule : factorial_core
